// File: rtl/feeder_pkg.sv
// feeder_pkg: shared types and constants for the joint feeder.
// Holds the FSM state encoding and the byte positions of the two
// operands inside a packed item.
package feeder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int A_LSB   = 0;
  localparam int B_LSB   = 8;
  localparam int FIELD_W = 8;

endpackage

// File: rtl/feeder_store.sv
// feeder_store: batch item storage for joint_feeder.
// All items are written at once when wr_en is high; one item is read
// combinationally by index. The store has no reset because its contents
// are only ever observed after a load has filled it.
module feeder_store
  import feeder_pkg::*;
#(
  parameter int ITEM_WIDTH = 16,
  parameter int JOINT_N    = 100,
  parameter int IDX_W      = $clog2(JOINT_N)
) (
  input  logic                          clk_i,
  input  logic                          wr_en,
  input  logic [JOINT_N*ITEM_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic [ITEM_WIDTH-1:0]         rd_item
);

  logic [ITEM_WIDTH-1:0] items [JOINT_N];

  // Capture every item of the packed batch in a single cycle.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < JOINT_N; k++) begin
        items[k] <= wr_data[k*ITEM_WIDTH +: ITEM_WIDTH];
      end
    end
  end

  assign rd_item = items[rd_idx];

endmodule

// File: rtl/joint_feeder.sv
// joint_feeder: presents a captured batch of items as (A, B) byte pairs,
// one pair per accepted transfer, under a valid/ready handshake.
// Build option: define FEEDER_LOOP_EN to replay the batch forever instead
// of returning to IDLE after the final item.
module joint_feeder
  import feeder_pkg::*;
#(
  parameter int ITEM_WIDTH = 16,
  parameter int JOINT_N    = 100
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          load_i,
  input  logic [JOINT_N*ITEM_WIDTH-1:0] data_i,
  output logic [7:0]                    a_o,
  output logic [7:0]                    b_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          last_o,
  output logic                          busy_o,
  output logic [$clog2(JOINT_N)-1:0]    count_o,
  output logic                          xmit_en_o
);

  localparam int CNT_W = $clog2(JOINT_N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(JOINT_N - 1);

  state_t state, state_n;

  logic [CNT_W-1:0]      count_n;
  logic [7:0]            a_n;
  logic [7:0]            b_n;
  logic                  valid_n;
  logic                  last_n;
  logic                  busy_n;
  logic                  xmit_n;
  logic                  store_wr;
  logic [CNT_W-1:0]      rd_idx;
  logic [ITEM_WIDTH-1:0] rd_item;

  // A load is only honoured from IDLE and never in a reset cycle, so a
  // running batch cannot be overwritten underneath the reader.
  assign store_wr = (state == IDLE) && load_i && !reset_i;

  // The store is always addressed with the item that follows the one on
  // the outputs, so a transfer can register it directly.
  assign rd_idx = (count_o == LAST_IDX) ? '0 : count_o + CNT_W'(1);

  feeder_store #(
    .ITEM_WIDTH(ITEM_WIDTH),
    .JOINT_N   (JOINT_N),
    .IDX_W     (CNT_W)
  ) u_store (
    .clk_i  (clk_i),
    .wr_en  (store_wr),
    .wr_data(data_i),
    .rd_idx (rd_idx),
    .rd_item(rd_item)
  );

  // Bits above the two operand bytes carry no meaning for this block.
  if (ITEM_WIDTH > 16) begin : g_item_hi
    logic unused_item_hi;
    assign unused_item_hi = ^rd_item[ITEM_WIDTH-1:16];
  end

  // Next-state and next-output decision; every output is registered below.
  always_comb begin
    state_n = state;
    count_n = count_o;
    a_n     = a_o;
    b_n     = b_o;
    valid_n = valid_o;
    last_n  = last_o;
    busy_n  = busy_o;
    xmit_n  = xmit_en_o;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
        if (load_i) begin
          // Item 0 comes straight from the input bus because the store
          // is being written on this same edge.
          state_n = STREAM;
          count_n = '0;
          a_n     = data_i[A_LSB +: FIELD_W];
          b_n     = data_i[B_LSB +: FIELD_W];
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      STREAM: begin
        valid_n = 1'b1;
        busy_n  = 1'b1;
        if (valid_o && ready_i) begin
          count_n = rd_idx;
          a_n     = rd_item[A_LSB +: FIELD_W];
          b_n     = rd_item[B_LSB +: FIELD_W];
          last_n  = (rd_idx == LAST_IDX);
          if (count_o == LAST_IDX) begin
            xmit_n = ~xmit_en_o;
`ifdef FEEDER_LOOP_EN
            // Wrap and replay item 0 on the next cycle.
            state_n = STREAM;
`else
            // Batch done: drop valid and keep the last pair on a/b.
            state_n = IDLE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            last_n  = 1'b0;
            a_n     = a_o;
            b_n     = b_o;
`endif
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Output registers; reset clears everything visible downstream.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_o       <= '0;
      b_o       <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      busy_o    <= 1'b0;
      count_o   <= '0;
      xmit_en_o <= 1'b0;
    end else begin
      a_o       <= a_n;
      b_o       <= b_n;
      valid_o   <= valid_n;
      last_o    <= last_n;
      busy_o    <= busy_n;
      count_o   <= count_n;
      xmit_en_o <= xmit_n;
    end
  end

endmodule

// File: tb/tb_joint_feeder.sv
// tb_joint_feeder: directed and randomized checks of joint_feeder against
// a batch-level reference model (items, position, batch counter).
module tb_joint_feeder;

  localparam int N  = 4;
  localparam int W  = 20;
  localparam int DW = N * W;
`ifdef FEEDER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          load_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_i = 1'b0;
  logic [7:0]    a_o;
  logic [7:0]    b_o;
  logic          valid_o;
  logic          last_o;
  logic          busy_o;
  logic [1:0]    count_o;
  logic          xmit_en_o;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [W-1:0] m_items [N];
  bit           m_stream = 1'b0;
  int           m_idx = 0;
  logic [7:0]   m_a = '0;
  logic [7:0]   m_b = '0;
  int           m_batches = 0;

  logic [DW-1:0] batch_a;
  logic [DW-1:0] batch_b;

  joint_feeder #(.ITEM_WIDTH(W), .JOINT_N(N)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (load_i),
    .data_i   (data_i),
    .a_o      (a_o),
    .b_o      (b_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .last_o   (last_o),
    .busy_o   (busy_o),
    .count_o  (count_o),
    .xmit_en_o(xmit_en_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] makeBatch(input logic [15:0] i0, input logic [15:0] i1,
                                               input logic [15:0] i2, input logic [15:0] i3);
    logic [DW-1:0] d;
    d[0*W +: W] = {4'($urandom), i0};
    d[1*W +: W] = {4'($urandom), i1};
    d[2*W +: W] = {4'($urandom), i2};
    d[3*W +: W] = {4'($urandom), i3};
    return d;
  endfunction

  task automatic checkOne(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs seen at that edge.
  task automatic modelStep();
    if (reset_i) begin
      m_stream  = 1'b0;
      m_idx     = 0;
      m_a       = '0;
      m_b       = '0;
      m_batches = 0;
    end else if (!m_stream) begin
      if (load_i) begin
        for (int k = 0; k < N; k++) m_items[k] = data_i[k*W +: W];
        m_stream = 1'b1;
        m_idx    = 0;
        m_a      = m_items[0][7:0];
        m_b      = m_items[0][15:8];
      end
    end else if (ready_i) begin
      if (m_idx == N - 1) begin
        m_batches++;
        m_idx = 0;
        if (LOOP) begin
          m_a = m_items[0][7:0];
          m_b = m_items[0][15:8];
        end else begin
          m_stream = 1'b0;
        end
      end else begin
        m_idx++;
        m_a = m_items[m_idx][7:0];
        m_b = m_items[m_idx][15:8];
      end
    end
  endtask

  task automatic checkOutput();
    checkOne("a_o", a_o, m_a);
    checkOne("b_o", b_o, m_b);
    checkOne("valid_o", valid_o, m_stream);
    checkOne("busy_o", busy_o, m_stream);
    checkOne("last_o", last_o, m_stream && (m_idx == N - 1));
    checkOne("count_o", count_o, m_idx);
    checkOne("xmit_en_o", xmit_en_o, m_batches % 2);
  endtask

  task automatic applyStimulus(input logic rst, input logic ld, input logic rdy,
                               input logic [DW-1:0] d);
    @(negedge clk_i);
    reset_i = rst;
    load_i  = ld;
    ready_i = rdy;
    data_i  = d;
    @(posedge clk_i);
    modelStep();
    #1;
    checkOutput();
  endtask

  initial begin
    batch_a = makeBatch(16'h0201, 16'h0403, 16'h0605, 16'h0807);
    batch_b = makeBatch(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h1122);

    // Reset with load asserted: load must be ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, batch_a);
    applyStimulus(1'b1, 1'b1, 1'b1, batch_a);
    checkOne("rst_valid", valid_o, 0);
    checkOne("rst_a", a_o, 0);

    // First cycle out of reset loads; ready held high.
    applyStimulus(1'b0, 1'b1, 1'b1, batch_a);
    checkOne("p0_a", a_o, 8'h01);
    checkOne("p0_b", b_o, 8'h02);
    checkOne("p0_valid", valid_o, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, batch_a);
    checkOne("p1_a", a_o, 8'h03);
    checkOne("p1_b", b_o, 8'h04);
    applyStimulus(1'b0, 1'b0, 1'b1, batch_a);
    checkOne("p2_a", a_o, 8'h05);
    applyStimulus(1'b0, 1'b0, 1'b1, batch_a);
    checkOne("p3_a", a_o, 8'h07);
    checkOne("p3_b", b_o, 8'h08);
    checkOne("p3_last", last_o, 1);
    checkOne("p3_xmit", xmit_en_o, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, batch_a);
    checkOne("end_xmit", xmit_en_o, 1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, batch_a);

    // Backpressure on item 1, then a load during item 2 that must be ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, batch_a);
    applyStimulus(1'b0, 1'b1, 1'b0, batch_a);
    applyStimulus(1'b0, 1'b0, 1'b1, batch_a);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, batch_a);
      checkOne("hold_a", a_o, 8'h03);
      checkOne("hold_b", b_o, 8'h04);
      checkOne("hold_cnt", count_o, 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, batch_a);
    checkOne("after_hold_a", a_o, 8'h05);
    checkOne("after_hold_b", b_o, 8'h06);
    applyStimulus(1'b0, 1'b1, 1'b1, batch_b);
    checkOne("ign_load_a", a_o, 8'h07);
    checkOne("ign_load_b", b_o, 8'h08);
    applyStimulus(1'b0, 1'b0, 1'b1, batch_b);

    // Reset while count_o==2, then a fresh load.
    applyStimulus(1'b1, 1'b0, 1'b0, batch_a);
    applyStimulus(1'b0, 1'b1, 1'b1, batch_a);
    applyStimulus(1'b0, 1'b0, 1'b1, batch_a);
    applyStimulus(1'b0, 1'b0, 1'b1, batch_a);
    checkOne("pre_rst_cnt", count_o, 2);
    applyStimulus(1'b1, 1'b0, 1'b1, batch_a);
    checkOne("mid_rst_a", a_o, 0);
    checkOne("mid_rst_busy", busy_o, 0);
    checkOne("mid_rst_cnt", count_o, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, batch_a);
    checkOne("reload_a", a_o, 8'h01);
    checkOne("reload_b", b_o, 8'h02);

    // Randomized traffic checked by the model alone.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
                    makeBatch(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
